// File: rtl/uart_pkg.sv
// Shared types and parameter limits for the UART transmit controller.
// Parameters outside these limits are rejected at elaboration.
package uart_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop
  } tx_state_e;

  localparam int unsigned ClksPerBitMin = 2;
  localparam int unsigned ClksPerBitMax = 65535;
  localparam int unsigned DataBitsMin   = 5;
  localparam int unsigned DataBitsMax   = 8;
  localparam int unsigned StopBitsMin   = 1;
  localparam int unsigned StopBitsMax   = 2;

  function automatic bit params_legal(input int unsigned clks_per_bit,
                                      input int unsigned data_bits,
                                      input int unsigned stop_bits);
    return (clks_per_bit >= ClksPerBitMin) && (clks_per_bit <= ClksPerBitMax) &&
           (data_bits >= DataBitsMin) && (data_bits <= DataBitsMax) &&
           (stop_bits >= StopBitsMin) && (stop_bits <= StopBitsMax);
  endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// Baud counter: counts 0..CLKS_PER_BIT-1 while enabled and flags the last cycle of a bit.
// Wrapping on bit_end means every state entered on bit_end starts from zero.
module uart_baud_cnt #(
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic bit_end
);

  localparam int unsigned CntW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(CLKS_PER_BIT - 1);

  logic [CntW-1:0] cnt_q;

  assign bit_end = (cnt_q == LastCnt);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (en) begin
      cnt_q <= bit_end ? '0 : cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART transmit controller: sequences start, data, optional parity and stop bits,
// driving an external shift register through load_en/shift_en.
module uart_tx_ctrl
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned PARITY_EN    = 0,
  parameter int unsigned PARITY_ODD   = 0,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  input  logic       sr_lsb,
  output logic       load_en,
  output logic       shift_en,
  output logic       tx_o,
  output logic       busy,
  output logic       done
);

  if (!params_legal(CLKS_PER_BIT, DATA_BITS, STOP_BITS)) begin : g_bad_params
    $error("uart_tx_ctrl: illegal CLKS_PER_BIT, DATA_BITS or STOP_BITS");
  end

  localparam logic [7:0] DataMask = 8'((1 << DATA_BITS) - 1);
  localparam logic [2:0] LastData = 3'(DATA_BITS - 1);
  localparam logic [2:0] LastStop = 3'(STOP_BITS - 1);
  localparam logic       ParOdd   = (PARITY_ODD != 0);
  localparam logic       ParEn    = (PARITY_EN != 0);

  tx_state_e  state_q;
  logic [2:0] bit_cnt_q;
  logic       parity_q;
  logic       bit_end;

  uart_baud_cnt #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud_cnt (
    .clk    (clk),
    .rst    (rst),
    .clr    (~busy),
    .en     (busy),
    .bit_end(bit_end)
  );

  // Gated by rst so a held tx_valid cannot pulse the shift register during reset.
  assign tx_ready = (state_q == StIdle);
  assign load_en  = tx_valid && tx_ready && !rst;
  assign busy     = (state_q != StIdle);
  assign shift_en = (state_q == StData) && bit_end;
  assign done     = (state_q == StStop) && bit_end && (bit_cnt_q == LastStop);

  always_comb begin
    tx_o = 1'b1;
    unique case (state_q)
      StIdle:   tx_o = 1'b1;
      StStart:  tx_o = 1'b0;
      StData:   tx_o = sr_lsb;
      StParity: tx_o = parity_q;
      StStop:   tx_o = 1'b1;
      default:  tx_o = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      bit_cnt_q <= '0;
      parity_q  <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (load_en) begin
            state_q  <= StStart;
            parity_q <= (^(tx_data & DataMask)) ^ ParOdd;
          end
        end
        StStart: begin
          if (bit_end) begin
            state_q   <= StData;
            bit_cnt_q <= '0;
          end
        end
        StData: begin
          if (bit_end) begin
            if (bit_cnt_q == LastData) begin
              state_q   <= ParEn ? StParity : StStop;
              bit_cnt_q <= '0;
            end else begin
              bit_cnt_q <= bit_cnt_q + 1'b1;
            end
          end
        end
        StParity: begin
          if (bit_end) begin
            state_q   <= StStop;
            bit_cnt_q <= '0;
          end
        end
        StStop: begin
          if (bit_end) begin
            if (bit_cnt_q == LastStop) begin
              state_q <= StIdle;
            end else begin
              bit_cnt_q <= bit_cnt_q + 1'b1;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Self-checking bench: five controller instances covering 8N1, 8E1, 8O1, 8N2 and 5N1,
// checked cycle by cycle against a frame-level model plus table and hand-written sequences.
module tb_uart_tx_ctrl;

  localparam int unsigned NInst = 5;
  localparam int unsigned Cpb   = 4;

  function automatic int unsigned db_of(input int unsigned g);
    return (g == 4) ? 5 : 8;
  endfunction
  function automatic int unsigned pe_of(input int unsigned g);
    return (g == 1 || g == 2) ? 1 : 0;
  endfunction
  function automatic int unsigned po_of(input int unsigned g);
    return (g == 2) ? 1 : 0;
  endfunction
  function automatic int unsigned sb_of(input int unsigned g);
    return (g == 3) ? 2 : 1;
  endfunction
  function automatic int flen(input int unsigned g);
    return int'(Cpb * (1 + db_of(g) + pe_of(g) + sb_of(g)));
  endfunction

  // Serial bit number idx of a frame carrying byte b: start, data LSB first, parity, stops.
  function automatic logic exp_bit(input int unsigned g, input logic [7:0] b, input int idx);
    logic [7:0] sh;
    logic [7:0] mask;
    if (idx == 0) return 1'b0;
    if (idx <= int'(db_of(g))) begin
      sh = b >> (idx - 1);
      return sh[0];
    end
    if (pe_of(g) != 0 && idx == int'(db_of(g)) + 1) begin
      mask = 8'((1 << db_of(g)) - 1);
      return (^(b & mask)) ^ (po_of(g) != 0);
    end
    return 1'b1;
  endfunction

  logic             clk;
  logic             rst;
  logic [NInst-1:0] tx_valid, tx_ready, load_en, shift_en, tx_o, busy, done;
  logic [7:0]       tx_data [NInst];

  for (genvar g = 0; g < NInst; g++) begin : g_dut
    logic [7:0] sr;
    always_ff @(posedge clk) begin
      if (load_en[g]) sr <= tx_data[g];
      else if (shift_en[g]) sr <= {1'b0, sr[7:1]};
    end
    uart_tx_ctrl #(
      .CLKS_PER_BIT(Cpb),
      .DATA_BITS   (db_of(g)),
      .PARITY_EN   (pe_of(g)),
      .PARITY_ODD  (po_of(g)),
      .STOP_BITS   (sb_of(g))
    ) u_dut (
      .clk     (clk),
      .rst     (rst),
      .tx_valid(tx_valid[g]),
      .tx_data (tx_data[g]),
      .tx_ready(tx_ready[g]),
      .sr_lsb  (sr[0]),
      .load_en (load_en[g]),
      .shift_en(shift_en[g]),
      .tx_o    (tx_o[g]),
      .busy    (busy[g]),
      .done    (done[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         g;
    logic [7:0] data;
    bit         poke;
    int         exp_len;
    int         exp_shifts;
    int         exp_nbits;
    logic [11:0] exp_line;
  } vec_t;

  vec_t vecs [7];
  vec_t post_rst_vec;

  int checks;
  int errors;

  logic [NInst-1:0] tv;
  logic [7:0]       td [NInst];
  int               mk [NInst];
  logic [7:0]       mcur [NInst];
  bit               seen_load [NInst];
  int               cyc [NInst];
  int               bcnt [NInst];
  int               scnt [NInst];
  int               done_at [NInst];
  logic [11:0]      line [NInst];
  bit               hist [120];

  task automatic check(input string name, input int g, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s inst=%0d got=%0h expected=%0h", name, g, act, exp);
    end
  endtask

  // One clock cycle: apply tv/td, compare every instance with the model, gather frame stats.
  task automatic step();
    @(negedge clk);
    tx_valid = tv;
    for (int g = 0; g < NInst; g++) tx_data[g] = td[g];
    #1;
    for (int g = 0; g < NInst; g++) begin
      logic [5:0] act_v;
      logic [5:0] exp_v;
      logic       sh_e;
      int         k;
      int         idx;
      int         ph;
      k = mk[g];
      act_v = {tx_ready[g], load_en[g], tx_o[g], busy[g], shift_en[g], done[g]};
      if (k == 0) begin
        exp_v = {1'b1, tv[g], 1'b1, 3'b000};
      end else begin
        idx   = (k - 1) / int'(Cpb);
        ph    = (k - 1) % int'(Cpb);
        sh_e  = (idx >= 1) && (idx <= int'(db_of(g))) && (ph == int'(Cpb) - 1);
        exp_v = {2'b00, exp_bit(g, mcur[g], idx), 1'b1, sh_e, (k == flen(g))};
      end
      check("outputs", g, int'(act_v), int'(exp_v));

      if (load_en[g]) begin
        seen_load[g] = 1'b1;
        cyc[g] = 0;
        bcnt[g] = 0;
        scnt[g] = 0;
        done_at[g] = 0;
        line[g] = '0;
      end else begin
        cyc[g]++;
        if (busy[g]) bcnt[g]++;
        if (shift_en[g]) scnt[g]++;
        if (done[g] && done_at[g] == 0) done_at[g] = cyc[g];
        if ((cyc[g] - 1) % int'(Cpb) == 1 && (cyc[g] - 1) / int'(Cpb) < 12)
          line[g] = line[g] | (12'(tx_o[g]) << ((cyc[g] - 1) / int'(Cpb)));
      end

      if (mk[g] == 0) begin
        if (tv[g]) begin
          mk[g] = 1;
          mcur[g] = td[g];
        end
      end else if (mk[g] == flen(g)) begin
        mk[g] = 0;
      end else begin
        mk[g]++;
      end
    end
  endtask

  task automatic run_vec(input vec_t v);
    logic [11:0] mask;
    seen_load[v.g] = 1'b0;
    tv[v.g] = 1'b1;
    td[v.g] = v.data;
    for (int c = 0; c < 50 && !seen_load[v.g]; c++) step();
    tv[v.g] = 1'b0;
    check("accept", v.g, int'(seen_load[v.g]), 1);
    for (int c = 0; c < 200 && done_at[v.g] == 0; c++) begin
      // A request while busy must be ignored.
      if (v.poke && cyc[v.g] == 10) begin
        tv[v.g] = 1'b1;
        td[v.g] = 8'h3C;
      end else begin
        tv[v.g] = 1'b0;
      end
      step();
    end
    tv[v.g] = 1'b0;
    mask = (12'h1 << v.exp_nbits) - 12'h1;
    check("frame_len", v.g, bcnt[v.g], v.exp_len);
    check("shift_pulses", v.g, scnt[v.g], v.exp_shifts);
    check("done_cycle", v.g, done_at[v.g], v.exp_len);
    check("line_bits", v.g, int'(line[v.g] & mask), int'(v.exp_line));
  endtask

  initial begin
    int loads;
    int i;
    int r1;
    int gap;
    int r2;

    checks = 0;
    errors = 0;
    tv = '0;
    for (int g = 0; g < NInst; g++) begin
      td[g] = 8'h00;
      tx_data[g] = 8'h00;
      mk[g] = 0;
      mcur[g] = 8'h00;
      seen_load[g] = 1'b0;
      cyc[g] = 0;
      bcnt[g] = 0;
      scnt[g] = 0;
      done_at[g] = 0;
      line[g] = '0;
    end

    vecs[0] = '{0, 8'hA5, 1'b0, 40, 8, 10, 12'h34A};
    vecs[1] = '{1, 8'h07, 1'b0, 44, 8, 11, 12'h60E};
    vecs[2] = '{2, 8'h07, 1'b0, 44, 8, 11, 12'h40E};
    vecs[3] = '{0, 8'h96, 1'b1, 40, 8, 10, 12'h32C};
    vecs[4] = '{4, 8'hFF, 1'b0, 28, 5, 7, 12'h07E};
    vecs[5] = '{1, 8'h00, 1'b0, 44, 8, 11, 12'h400};
    vecs[6] = '{4, 8'hE0, 1'b0, 28, 5, 7, 12'h040};
    post_rst_vec = '{0, 8'h55, 1'b0, 40, 8, 10, 12'h2AA};

    // Reset with tx_valid high: idle outputs and no load pulse.
    rst = 1'b1;
    tx_valid = '1;
    #3;
    for (int g = 0; g < NInst; g++)
      check("reset_state", g,
            int'({tx_ready[g], load_en[g], tx_o[g], busy[g], shift_en[g], done[g]}),
            int'(6'b101000));
    #9;
    rst = 1'b0;
    tx_valid = '0;

    foreach (vecs[n]) run_vec(vecs[n]);

    // Back-to-back 8N2 frames with tx_valid held high.
    loads = 0;
    tv[3] = 1'b1;
    td[3] = 8'h00;
    for (int c = 0; c < 120; c++) begin
      step();
      hist[c] = busy[3];
      if (load_en[3]) begin
        loads++;
        if (loads == 1) td[3] = 8'hFF;
        else tv[3] = 1'b0;
      end
    end
    tv[3] = 1'b0;
    i = 0;
    r1 = 0;
    gap = 0;
    r2 = 0;
    while (i < 120 && !hist[i]) i++;
    while (i < 120 && hist[i]) begin r1++; i++; end
    while (i < 120 && !hist[i]) begin gap++; i++; end
    while (i < 120 && hist[i]) begin r2++; i++; end
    check("b2b_loads", 3, loads, 2);
    check("b2b_frame1", 3, r1, 44);
    check("b2b_gap", 3, gap, 1);
    check("b2b_frame2", 3, r2, 44);

    // Asynchronous reset in the middle of data bit 3.
    seen_load[0] = 1'b0;
    tv[0] = 1'b1;
    td[0] = 8'hA5;
    for (int c = 0; c < 50 && !seen_load[0]; c++) step();
    tv[0] = 1'b0;
    for (int c = 0; c < 100 && cyc[0] != 18; c++) step();
    check("reach_data_bit3", 0, cyc[0], 18);
    tx_valid[0] = 1'b1;
    #2;
    rst = 1'b1;
    #1;
    check("async_reset", 0,
          int'({tx_ready[0], load_en[0], tx_o[0], busy[0], shift_en[0], done[0]}),
          int'(6'b101000));
    @(posedge clk);
    #1;
    rst = 1'b0;
    tx_valid = '0;
    for (int g = 0; g < NInst; g++) mk[g] = 0;
    run_vec(post_rst_vec);

    // Random traffic on all instances against the frame model.
    for (int c = 0; c < 2000; c++) begin
      for (int g = 0; g < NInst; g++) begin
        tv[g] = ($urandom_range(0, 3) == 0);
        td[g] = 8'($urandom);
      end
      step();
    end
    tv = '0;
    repeat (60) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
